// File: rtl/dm_byte_ram_if.sv
// Store/load port of the MEM-stage byte-enabled data memory.
// master drives the access, slave returns the registered, extended load result.
interface dm_byte_ram_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        re;
    logic [2:0]  ld_op;
    logic [31:0] rdata;
    logic        rd_valid;

    modport master (output addr, wdata, be, re, ld_op, input rdata, rd_valid);
    modport slave  (input addr, wdata, be, re, ld_op, output rdata, rd_valid);
endinterface

// File: rtl/dm_byte_ram.sv
// Byte-enabled 4 KiB data memory with write-first registered, sign/zero-extended loads.
// Latency: store 1 cycle, load 1 cycle; always ready, no backpressure.
module dm_byte_ram #(
    parameter int WORDS = 1024
) (
    input  logic          clk,
    input  logic          reset,
    dm_byte_ram_if.slave  bus
);
    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem [WORDS];
    logic [AW-1:0] idx;
    logic          in_range;
    logic          we;
    logic [31:0]   lane_dat;
    logic [31:0]   cur;
    logic [31:0]   merged;
    logic [31:0]   rd_word;
    logic [31:0]   ld_ext;

    assign idx      = bus.addr[AW+1:2];
    assign in_range = (bus.addr[31:12] == 20'h0);
    assign we       = in_range && (bus.be != 4'b0000);
    assign cur      = mem[idx];

    // Right-aligned store data is replicated so every lane a narrow mask selects sees it.
    always_comb begin
        lane_dat = bus.wdata;
        case (bus.be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: lane_dat = {4{bus.wdata[7:0]}};
            4'b0011, 4'b1100:                   lane_dat = {2{bus.wdata[15:0]}};
            default:                            lane_dat = bus.wdata;
        endcase
    end

    always_comb begin
        merged = cur;
        for (int i = 0; i < 4; i++) begin
            if (bus.be[i]) begin
                merged[8*i +: 8] = lane_dat[8*i +: 8];
            end
        end
    end

    // Write-first: a load colliding with a store sees the merged word.
    assign rd_word = we ? merged : cur;

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h00;
        case (bus.addr[1:0])
            2'd0:    b = rd_word[7:0];
            2'd1:    b = rd_word[15:8];
            2'd2:    b = rd_word[23:16];
            default: b = rd_word[31:24];
        endcase
        h = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (bus.ld_op)
            3'd2:    ld_ext = {24'h0, b};
            3'd3:    ld_ext = {{24{b[7]}}, b};
            3'd4:    ld_ext = {16'h0, h};
            3'd5:    ld_ext = {{16{h[15]}}, h};
            default: ld_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= 32'h0;
            end
            bus.rdata    <= 32'h0;
            bus.rd_valid <= 1'b0;
        end else begin
            if (we) begin
                mem[idx] <= merged;
            end
            bus.rd_valid <= bus.re;
            if (bus.re) begin
                bus.rdata <= in_range ? ld_ext : 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_dm_byte_ram.sv
// Self-checking bench for dm_byte_ram: directed test-plan steps, then random traffic
// checked against a byte-addressed reference model.
module tb_dm_byte_ram;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dm_byte_ram_if bus ();

    dm_byte_ram #(.WORDS(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain byte array plus expected output registers.
    logic [7:0]  mb [4096];
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_valid = 1'b0;

    function automatic logic [7:0] src_byte(input logic [3:0] m, input logic [31:0] wd, input int lane);
        if ($countones(m) == 1) return wd[7:0];
        if (m == 4'b0011 || m == 4'b1100) return (lane % 2 == 0) ? wd[7:0] : wd[15:8];
        return wd[8*lane +: 8];
    endfunction

    function automatic logic [31:0] model_load(input logic [11:0] a, input logic [2:0] op);
        int          bi;
        int          hi;
        int          wi;
        logic [15:0] h;
        bi = int'(a);
        hi = int'(a) & ~1;
        wi = int'(a) & ~3;
        h  = {mb[hi+1], mb[hi]};
        case (op)
            3'd2:    return {24'h0, mb[bi]};
            3'd3:    return {{24{mb[bi][7]}}, mb[bi]};
            3'd4:    return {16'h0, h};
            3'd5:    return {{16{h[15]}}, h};
            default: return {mb[wi+3], mb[wi+2], mb[wi+1], mb[wi]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access: inputs applied after a falling edge, outputs checked at the next falling edge.
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                        input logic r, input logic [2:0] op, input logic rst);
        bus.addr  = a;
        bus.wdata = wd;
        bus.be    = m;
        bus.re    = r;
        bus.ld_op = op;
        reset     = rst;
        @(posedge clk);
        if (!rst) begin
            foreach (mb[i]) mb[i] = 8'h00;
            exp_rdata = 32'h0;
            exp_valid = 1'b0;
        end else begin
            if (a[31:12] == 20'h0) begin
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) mb[int'(a[11:0] & 12'hFFC) + i] = src_byte(m, wd, i);
                end
            end
            exp_valid = r;
            if (r) exp_rdata = (a[31:12] == 20'h0) ? model_load(a[11:0], op) : 32'h0;
        end
        @(negedge clk);
        check("rdata", bus.rdata, exp_rdata);
        check("rd_valid", {31'h0, bus.rd_valid}, {31'h0, exp_valid});
    endtask

    initial begin
        logic [3:0]  masks [8];
        logic [31:0] a;
        logic [3:0]  m;
        masks = '{4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b0000};

        bus.addr = 32'h0; bus.wdata = 32'h0; bus.be = 4'h0; bus.re = 1'b0; bus.ld_op = 3'd1;
        reset = 1'b0;
        @(negedge clk);

        // Reset then read every word.
        step(32'h0, 32'h0, 4'h0, 1'b0, 3'd1, 1'b0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_valid", {31'h0, bus.rd_valid}, 32'h0);
        for (int i = 0; i < 1024; i++) step(32'(i * 4), 32'h0, 4'h0, 1'b1, 3'd1, 1'b1);

        // Byte lanes.
        step(32'h10, 32'h11223344, 4'b1111, 1'b0, 3'd1, 1'b1);
        step(32'h12, 32'h000000AB, 4'b0100, 1'b0, 3'd1, 1'b1);
        step(32'h10, 32'h0, 4'h0, 1'b1, 3'd1, 1'b1);
        check("lw_0x10", bus.rdata, 32'h11AB3344);
        step(32'h12, 32'h0, 4'h0, 1'b1, 3'd3, 1'b1);
        check("lb_0x12", bus.rdata, 32'hFFFFFFAB);
        step(32'h12, 32'h0, 4'h0, 1'b1, 3'd2, 1'b1);
        check("lbu_0x12", bus.rdata, 32'h000000AB);

        // Halves.
        step(32'h20, 32'h00008001, 4'b1100, 1'b0, 3'd1, 1'b1);
        step(32'h20, 32'h0, 4'h0, 1'b1, 3'd1, 1'b1);
        check("lw_0x20", bus.rdata, 32'h80010000);
        step(32'h22, 32'h0, 4'h0, 1'b1, 3'd5, 1'b1);
        check("lh_0x22", bus.rdata, 32'hFFFF8001);
        step(32'h22, 32'h0, 4'h0, 1'b1, 3'd4, 1'b1);
        check("lhu_0x22", bus.rdata, 32'h00008001);
        step(32'h20, 32'h0, 4'h0, 1'b1, 3'd5, 1'b1);
        check("lh_0x20", bus.rdata, 32'h00000000);

        // Write-first collision.
        step(32'h30, 32'hDEADBEEF, 4'b1111, 1'b0, 3'd1, 1'b1);
        step(32'h30, 32'h00000055, 4'b0001, 1'b1, 3'd1, 1'b1);
        check("collide", bus.rdata, 32'hDEADBE55);
        check("collide_v", {31'h0, bus.rd_valid}, 32'h1);

        // Out of range: store dropped, load returns zero, no alias onto word 0.
        step(32'h00001000, 32'hCAFEF00D, 4'b1111, 1'b0, 3'd1, 1'b1);
        step(32'h00001000, 32'h0, 4'h0, 1'b1, 3'd1, 1'b1);
        check("oor_rdata", bus.rdata, 32'h0);
        check("oor_valid", {31'h0, bus.rd_valid}, 32'h1);
        step(32'h0, 32'h0, 4'h0, 1'b1, 3'd1, 1'b1);
        check("no_alias", bus.rdata, 32'h0);

        // Store during reset is discarded; reset squashes a pending load result.
        step(32'h40, 32'h12345678, 4'b1111, 1'b0, 3'd1, 1'b0);
        step(32'h40, 32'h0, 4'h0, 1'b1, 3'd1, 1'b1);
        check("rst_store", bus.rdata, 32'h0);
        step(32'h40, 32'h12345678, 4'b1111, 1'b0, 3'd1, 1'b1);
        step(32'h40, 32'h0, 4'h0, 1'b1, 3'd1, 1'b1);
        check("pre_rst", bus.rdata, 32'h12345678);
        step(32'h40, 32'h0, 4'h0, 1'b0, 3'd1, 1'b0);
        check("rst_rd", bus.rdata, 32'h0);
        check("rst_rv", {31'h0, bus.rd_valid}, 32'h0);

        // Random traffic over a small window so stores and loads collide often.
        for (int n = 0; n < 3000; n++) begin
            a = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 255));
            m = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : masks[$urandom_range(0, 7)];
            step(a, $urandom(), m, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_byte_ram.md
# dm_byte_ram

Byte-enabled data memory for the MEM stage of the pipelined MIPS core. It sits directly downstream of the store byte-enable generator and consumes its 4-bit lane mask together with the store address and data. It steers store data onto the selected byte lanes and writes a 1024-word (4 KiB) array. It also performs registered reads with load sign/zero extension, so the value handed to the MEM/WB register is already extended.

## Interface
- `WORDS`, 1024, number of 32-bit words; index is `addr[11:2]`
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`
- `addr` in 32: byte address of the access
- `wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0])
- `be` in 4: lane mask from the byte-enable generator; 0000 means no write
- `re` in 1: load request this cycle
- `ld_op` in 3: 1=lw, 2=lbu, 3=lb, 4=lhu, 5=lh; other values read as lw
- `rdata` out 32: extended load result, registered
- `rd_valid` out 1: high the cycle after an accepted load

## Operation
- Range check: an access is in range iff `addr[31:12]==0`. Out-of-range stores are dropped. Out-of-range loads set `rd_valid`=1 and `rdata`=0.
- Lane steering for stores, from `be`:
  - 1111: word = `wdata`
  - 0001/0010/0100/1000: `wdata[7:0]` goes to lane 0/1/2/3
  - 0011: `wdata[15:0]` goes to lanes 1:0
  - 1100: `wdata[15:0]` goes to lanes 3:2
  - Any other non-zero mask writes `wdata` lane-for-lane under the mask.
- Write: on the clock edge, only lanes with `be[i]=1` update `mem[addr[11:2]]`; other lanes keep their value.
- Read: on the clock edge with `re=1`, the block selects word `mem[addr[11:2]]`, then extracts and extends using `addr[1:0]`:
  - lbu/lb: byte at lane `addr[1:0]`, zero- or sign-extended (bit 7)
  - lhu/lh: half at lanes `{addr[1],0}`, zero- or sign-extended (bit 15)
  - lw: whole word
- Simultaneous store and load to the same word in one cycle is write-first: the load sees the merged post-write word.
- `rdata` holds its last value when `re=0`. `rd_valid` is a one-cycle pulse per load.
- Reset (`reset`=0 at an edge): all `WORDS` entries cleared to 0, `rdata`=0, `rd_valid`=0. Any store or load presented in that cycle is discarded.

## Timing
- Store: 1 cycle; the array is updated at the edge where `be` is non-zero.
- Load latency: 1 cycle. Inputs are sampled at edge N; `rdata`/`rd_valid` are valid after edge N and stable through edge N+1.
- Back-to-back loads every cycle are supported; `rd_valid` stays high continuously.
- Back-to-back store then load to the same address in consecutive cycles returns the new data. No hazard logic is needed because the store is committed at the first edge.
- No combinational path from any input to `rdata` or `rd_valid`.
- Reset takes effect at the first edge with `reset`=0 and lasts one cycle. Outputs are 0 from that edge until the first load after release.

## Test plan
- Reset then read-all: hold `reset`=0 for 1 cycle, then lw every word 0..1023 -> every `rdata`=0x00000000 with `rd_valid`=1 each cycle.
- Byte lanes: sw 0x11223344 @0x10, then sb `wdata`=0xAB with `be`=0100 @0x12, then lw @0x10 -> 0x11AB3344. Then lb @0x12 -> 0xFFFFFFAB, and lbu @0x12 -> 0x000000AB.
- Halves: sh 0x8001 with `be`=1100 @0x20 over a zeroed word -> lw @0x20 = 0x80010000. Then lh @0x22 -> 0xFFFF8001, lhu @0x22 -> 0x00008001, lh @0x20 -> 0x00000000.
- Write-first collision: with word @0x30 = 0xDEADBEEF, issue sb 0x55 with `be`=0001 and lw @0x30 in the same cycle -> `rdata`=0xDEADBE55 next cycle.
- Out of range: sw 0xCAFEF00D @0x00001000, then lw @0x00001000 -> `rdata`=0, `rd_valid`=1. Then lw @0x0 -> unchanged value (no aliasing).
- Reset mid-operation: store @0x40 with `reset`=0 in the same cycle -> word stays 0. Also assert reset while `rd_valid`=1 -> next cycle `rdata`=0, `rd_valid`=0.
